// File: rtl/msrh_csr_counter_resp.sv
`default_nettype none
// ============================================================================
// Module      : msrh_csr_counter_resp (with supporting packages/interfaces)
// Description : Responder for the counter CSR group. Serves mcycle, minstret,
//               mcountinhibit, mcounteren, scounteren, the user aliases
//               cycle/instret and the hpmcounter/hpmevent placeholders.
//               Read data and read/write errors are combinational so the
//               CSU pipe can consume them in the same stage.
// Ports       : i_clk, i_reset_n (async, active-low), i_status_priv,
//               i_retire_cnt, read_if (csr_rd_if.slave),
//               write_if (csr_wr_if.slave), o_mcycle, o_minstret
// Revision    : 1.0 - initial release
// ============================================================================

package riscv_pkg;
    localparam int XLEN_W = 64;
endpackage

package msrh_conf_pkg;
    localparam int DISP_SIZE = 5;
endpackage

package msrh_pkg;
    typedef enum logic [1:0] {
        PRV_U = 2'd0,
        PRV_S = 2'd1,
        PRV_M = 2'd3
    } priv_t;
endpackage

interface csr_rd_if;
    logic                        valid;
    logic [11:0]                 addr;
    logic [riscv_pkg::XLEN_W-1:0] data;
    logic                        resp_error;

    modport master (output valid, output addr, input data, input resp_error);
    modport slave  (input valid, input addr, output data, output resp_error);
endinterface

interface csr_wr_if;
    logic                        valid;
    logic [11:0]                 addr;
    logic [riscv_pkg::XLEN_W-1:0] data;
    logic                        resp_error;

    modport master (output valid, output addr, output data, input resp_error);
    modport slave  (input valid, input addr, input data, output resp_error);
endinterface

module msrh_csr_counter_resp #(
    parameter int          RETIRE_W    = $clog2(msrh_conf_pkg::DISP_SIZE + 1),
    parameter logic [63:0] MCYCLE_INIT = 64'h0
) (
    input  logic                i_clk,
    input  logic                i_reset_n,
    input  msrh_pkg::priv_t     i_status_priv,
    input  logic [RETIRE_W-1:0] i_retire_cnt,
    csr_rd_if.slave             read_if,
    csr_wr_if.slave             write_if,
    output logic [63:0]         o_mcycle,
    output logic [63:0]         o_minstret
);

    localparam logic [11:0] c_ADDR_MCYCLE     = 12'hB00;
    localparam logic [11:0] c_ADDR_MINSTRET   = 12'hB02;
    localparam logic [11:0] c_ADDR_MCNTINHIB  = 12'h320;
    localparam logic [11:0] c_ADDR_MCOUNTEREN = 12'h306;
    localparam logic [11:0] c_ADDR_SCOUNTEREN = 12'h106;
    localparam logic [11:0] c_ADDR_CYCLE      = 12'hC00;
    localparam logic [11:0] c_ADDR_TIME       = 12'hC01;
    localparam logic [11:0] c_ADDR_INSTRET    = 12'hC02;

    // 32-entry blocks (addr[11:5]) that hold the hpm placeholders at offsets 3..31
    localparam logic [6:0]  c_BLK_MHPMCNT     = 7'h58;  // 0xB00
    localparam logic [6:0]  c_BLK_MHPMEVT     = 7'h19;  // 0x320
    localparam logic [6:0]  c_BLK_HPMCNT      = 7'h60;  // 0xC00

    // Counter state. Only CY (bit 0) and IR (bit 2) of the enable/inhibit
    // CSRs exist, so they are held as individual flops.
    logic [63:0] r_mcycle;
    logic [63:0] r_minstret;
    logic        r_inh_cy;
    logic        r_inh_ir;
    logic        r_men_cy;
    logic        r_men_ir;
    logic        r_sen_cy;
    logic        r_sen_ir;

    logic [1:0]  w_priv;
    assign w_priv = i_status_priv;

    // ------------------------------------------------------------------------
    // Read port
    // ------------------------------------------------------------------------
    logic [63:0] w_rd_raw;
    logic        w_rd_mapped;
    logic        w_rd_alias;
    logic        w_rd_alias_ir;   // alias selects IR bit (instret) rather than CY
    logic        w_rd_men_k;
    logic        w_rd_sen_k;
    logic        w_rd_alias_ok;
    logic        w_rd_hpm;
    logic        w_rd_err;

    assign w_rd_hpm = (read_if.addr[4:0] >= 5'd3) &&
                      ((read_if.addr[11:5] == c_BLK_MHPMCNT) ||
                       (read_if.addr[11:5] == c_BLK_MHPMEVT) ||
                       (read_if.addr[11:5] == c_BLK_HPMCNT));

    always_comb begin
        w_rd_raw      = 64'h0;
        w_rd_mapped   = 1'b1;
        w_rd_alias    = 1'b0;
        w_rd_alias_ir = 1'b0;
        if (read_if.addr == c_ADDR_MCYCLE) begin
            w_rd_raw = r_mcycle;
        end else if (read_if.addr == c_ADDR_MINSTRET) begin
            w_rd_raw = r_minstret;
        end else if (read_if.addr == c_ADDR_MCNTINHIB) begin
            w_rd_raw = {61'h0, r_inh_ir, 1'b0, r_inh_cy};
        end else if (read_if.addr == c_ADDR_MCOUNTEREN) begin
            w_rd_raw = {61'h0, r_men_ir, 1'b0, r_men_cy};
        end else if (read_if.addr == c_ADDR_SCOUNTEREN) begin
            w_rd_raw = {61'h0, r_sen_ir, 1'b0, r_sen_cy};
        end else if (read_if.addr == c_ADDR_CYCLE) begin
            w_rd_raw   = r_mcycle;
            w_rd_alias = 1'b1;
        end else if (read_if.addr == c_ADDR_INSTRET) begin
            w_rd_raw      = r_minstret;
            w_rd_alias    = 1'b1;
            w_rd_alias_ir = 1'b1;
        end else if (w_rd_hpm) begin
            w_rd_raw = 64'h0;
        end else begin
            // Includes 0xC01 (time lives in the timer CSR) and gaps like 0xB01.
            w_rd_mapped = 1'b0;
        end
    end

    assign w_rd_men_k = w_rd_alias_ir ? r_men_ir : r_men_cy;
    assign w_rd_sen_k = w_rd_alias_ir ? r_sen_ir : r_sen_cy;

    always_comb begin
        w_rd_alias_ok = 1'b0;
        case (w_priv)
            2'd3:    w_rd_alias_ok = 1'b1;
            2'd1:    w_rd_alias_ok = w_rd_men_k;
            2'd0:    w_rd_alias_ok = w_rd_men_k & w_rd_sen_k;
            default: w_rd_alias_ok = 1'b0;
        endcase
    end

    assign w_rd_err = read_if.valid &
                      ((w_priv < read_if.addr[9:8]) |
                       (w_rd_alias & ~w_rd_alias_ok) |
                       ~w_rd_mapped);

    assign read_if.resp_error = w_rd_err;
    assign read_if.data       = (read_if.valid & ~w_rd_err) ? w_rd_raw : 64'h0;

    // ------------------------------------------------------------------------
    // Write port
    // ------------------------------------------------------------------------
    logic w_wr_err;
    logic w_wr_en;

    assign w_wr_err = write_if.valid &
                      ((write_if.addr[11:10] == 2'b11) |
                       (w_priv < write_if.addr[9:8]) |
                       (write_if.addr == c_ADDR_TIME));
    assign w_wr_en  = write_if.valid & ~w_wr_err;

    assign write_if.resp_error = w_wr_err;

    // ------------------------------------------------------------------------
    // State update. The inhibit bits used here are the pre-write values, so a
    // write to mcountinhibit only affects increments from the next cycle on.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_mcycle   <= MCYCLE_INIT;
            r_minstret <= 64'h0;
            r_inh_cy   <= 1'b0;
            r_inh_ir   <= 1'b0;
            r_men_cy   <= 1'b0;
            r_men_ir   <= 1'b0;
            r_sen_cy   <= 1'b0;
            r_sen_ir   <= 1'b0;
        end else begin
            if (w_wr_en && (write_if.addr == c_ADDR_MCYCLE)) begin
                r_mcycle <= write_if.data;
            end else if (!r_inh_cy) begin
                r_mcycle <= r_mcycle + 64'd1;
            end

            // A direct write wins and the same-cycle retire count is dropped.
            if (w_wr_en && (write_if.addr == c_ADDR_MINSTRET)) begin
                r_minstret <= write_if.data;
            end else if (!r_inh_ir) begin
                r_minstret <= r_minstret + {{(64-RETIRE_W){1'b0}}, i_retire_cnt};
            end

            if (w_wr_en && (write_if.addr == c_ADDR_MCNTINHIB)) begin
                r_inh_cy <= write_if.data[0];
                r_inh_ir <= write_if.data[2];
            end
            if (w_wr_en && (write_if.addr == c_ADDR_MCOUNTEREN)) begin
                r_men_cy <= write_if.data[0];
                r_men_ir <= write_if.data[2];
            end
            if (w_wr_en && (write_if.addr == c_ADDR_SCOUNTEREN)) begin
                r_sen_cy <= write_if.data[0];
                r_sen_ir <= write_if.data[2];
            end
        end
    end

    assign o_mcycle   = r_mcycle;
    assign o_minstret = r_minstret;

endmodule
`default_nettype wire

// File: tb/tb_msrh_csr_counter_resp.sv
`default_nettype none
// ============================================================================
// Module      : tb_msrh_csr_counter_resp
// Description : Self-checking bench for msrh_csr_counter_resp. A behavioural
//               model of the counter CSRs is compared against the DUT on every
//               falling edge; directed sequences pin literal values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_msrh_csr_counter_resp;

    localparam int RW = $clog2(msrh_conf_pkg::DISP_SIZE + 1);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    msrh_pkg::priv_t priv;
    logic [RW-1:0]   retire;
    logic [63:0]     mcycle;
    logic [63:0]     minstret;

    csr_rd_if u_rd ();
    csr_wr_if u_wr ();

    always #5 clk = ~clk;

    msrh_csr_counter_resp #(
        .MCYCLE_INIT (64'h0)
    ) u_dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_status_priv (priv),
        .i_retire_cnt  (retire),
        .read_if       (u_rd),
        .write_if      (u_wr),
        .o_mcycle      (mcycle),
        .o_minstret    (minstret)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------------
    // Reference model: architectural counter CSR state
    // ------------------------------------------------------------------------
    logic [63:0] m_cy, m_ir, m_inh, m_men, m_sen;

    function automatic bit lower_priv(input logic [11:0] a);
        return int'(priv) < int'(a[9:8]);
    endfunction

    function automatic bit in_hpm(input logic [11:0] a);
        return (a >= 12'hB03 && a <= 12'hB1F) ||
               (a >= 12'h323 && a <= 12'h33F) ||
               (a >= 12'hC03 && a <= 12'hC1F);
    endfunction

    // Returns {error, data} for the current read request.
    function automatic logic [64:0] model_read();
        logic [11:0] a;
        logic [63:0] d;
        bit          err;
        int          k;
        a   = u_rd.addr;
        d   = 64'h0;
        err = lower_priv(a);
        if (!u_rd.valid) return 65'h0;
        case (a)
            12'hB00: d = m_cy;
            12'hB02: d = m_ir;
            12'h320: d = m_inh;
            12'h306: d = m_men;
            12'h106: d = m_sen;
            12'hC00, 12'hC02: begin
                d = (a == 12'hC00) ? m_cy : m_ir;
                k = (a == 12'hC00) ? 0 : 2;
                if (priv == msrh_pkg::PRV_S && !m_men[k]) err = 1;
                if (priv == msrh_pkg::PRV_U && !(m_men[k] && m_sen[k])) err = 1;
            end
            default: if (!in_hpm(a)) err = 1;
        endcase
        return err ? {1'b1, 64'h0} : {1'b0, d};
    endfunction

    function automatic bit model_wr_err();
        return u_wr.valid && (u_wr.addr[11:10] == 2'b11 || lower_priv(u_wr.addr) ||
                              u_wr.addr == 12'hC01);
    endfunction

    function automatic bit model_wr_to(input logic [11:0] a);
        return u_wr.valid && !model_wr_err() && u_wr.addr == a;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cy  <= 64'h0;
            m_ir  <= 64'h0;
            m_inh <= 64'h0;
            m_men <= 64'h0;
            m_sen <= 64'h0;
        end else begin
            if (model_wr_to(12'hB00))  m_cy <= u_wr.data;
            else if (!m_inh[0])        m_cy <= m_cy + 1;
            if (model_wr_to(12'hB02))  m_ir <= u_wr.data;
            else if (!m_inh[2])        m_ir <= m_ir + 64'(retire);
            if (model_wr_to(12'h320))  m_inh <= u_wr.data & 64'h5;
            if (model_wr_to(12'h306))  m_men <= u_wr.data & 64'h5;
            if (model_wr_to(12'h106))  m_sen <= u_wr.data & 64'h5;
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        logic [64:0] e;
        if (rst_n === 1'b1) begin
            e = model_read();
            chk("o_mcycle",   mcycle,            m_cy);
            chk("o_minstret", minstret,          m_ir);
            chk("rd_err",     64'(u_rd.resp_error), 64'(e[64]));
            chk("rd_data",    u_rd.data,         e[63:0]);
            chk("wr_err",     64'(u_wr.resp_error), 64'(model_wr_err()));
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic idle();
        u_rd.valid = 1'b0; u_rd.addr = 12'h0;
        u_wr.valid = 1'b0; u_wr.addr = 12'h0; u_wr.data = 64'h0;
        retire = '0;
        priv = msrh_pkg::PRV_M;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [11:0] a);
        u_rd.valid = 1'b1; u_rd.addr = a;
    endtask

    task automatic wr(input logic [11:0] a, input logic [63:0] d);
        u_wr.valid = 1'b1; u_wr.addr = a; u_wr.data = d;
    endtask

    logic [11:0] rd_pool [16] = '{12'hB00, 12'hB02, 12'h320, 12'h306, 12'h106, 12'hC00,
                                  12'hC02, 12'hC01, 12'hB01, 12'hB05, 12'h33F, 12'hC1F,
                                  12'h321, 12'hC20, 12'hB1F, 12'h323};
    logic [11:0] wr_pool [12] = '{12'h320, 12'h306, 12'h106, 12'h320, 12'h306, 12'h106,
                                  12'hC00, 12'hC01, 12'hC02, 12'hB07, 12'h325, 12'hB01};

    logic [63:0] c0, i0;

    initial begin
        idle();
        // Reset state
        tick(3);
        chk("reset_mcycle",   mcycle,   64'h0);
        chk("reset_minstret", minstret, 64'h0);
        rst_n = 1'b1;

        // Free-running mcycle from reset release
        tick(10);
        rd(12'hB00);
        #1;
        chk("cycle_after_10", u_rd.data, 64'd10);
        chk("minstret_idle",  minstret,  64'd0);

        // Retirement and minstret write precedence
        u_rd.valid = 1'b0;
        retire = RW'(2);
        tick(5);
        retire = '0;
        rd(12'hB02);
        #1;
        chk("minstret_10", u_rd.data, 64'd10);
        wr(12'hB02, 64'h100);
        retire = RW'(2);
        #1;
        chk("rd_old_during_wr", u_rd.data, 64'd10);
        tick(1);
        u_wr.valid = 1'b0;
        #1;
        chk("minstret_written", u_rd.data, 64'h100);
        tick(1);
        retire = '0;
        #1;
        chk("minstret_plus2", u_rd.data, 64'h102);

        // Inhibit: old value governs in the write cycle
        idle();
        wr(12'h320, 64'hFFFF_FFFF_FFFF_FFFF);
        #1;
        c0 = mcycle;
        tick(1);
        idle();
        rd(12'h320);
        #1;
        chk("inhib_first", mcycle, c0 + 1);
        chk("inhib_read_mask", u_rd.data, 64'h5);
        retire = RW'(3);
        i0 = minstret;
        tick(4);
        chk("inhib_cy_frozen", mcycle, c0 + 1);
        chk("inhib_ir_frozen", minstret, i0);
        wr(12'h320, 64'h0);
        retire = '0;
        tick(1);
        idle();
        #1;
        chk("inhib_release_same", mcycle, c0 + 1);
        tick(1);
        chk("inhib_resumed", mcycle, c0 + 2);

        // Counter-enable gating of user aliases
        wr(12'h306, 64'h1);
        tick(1);
        wr(12'h106, 64'h0);
        tick(1);
        idle();
        priv = msrh_pkg::PRV_U;
        rd(12'hC00);
        #1;
        chk("u_cycle_denied_err",  64'(u_rd.resp_error), 64'd1);
        chk("u_cycle_denied_data", u_rd.data, 64'd0);
        priv = msrh_pkg::PRV_M;
        wr(12'h106, 64'h1);
        tick(1);
        idle();
        priv = msrh_pkg::PRV_U;
        rd(12'hC00);
        #1;
        chk("u_cycle_ok_err",  64'(u_rd.resp_error), 64'd0);
        chk("u_cycle_ok_data", u_rd.data, mcycle);
        rd(12'hC02);
        #1;
        chk("u_instret_denied", 64'(u_rd.resp_error), 64'd1);

        // Write errors
        idle();
        priv = msrh_pkg::PRV_S;
        wr(12'hB00, 64'h1234);
        #1;
        chk("s_wr_mcycle_err", 64'(u_wr.resp_error), 64'd1);
        c0 = mcycle;
        tick(1);
        idle();
        chk("s_wr_ignored", mcycle, c0 + 1);
        wr(12'hC02, 64'h5);
        rd(12'hC01);
        #1;
        chk("wr_instret_ro", 64'(u_wr.resp_error), 64'd1);
        chk("rd_time_err",   64'(u_rd.resp_error), 64'd1);

        // 64-bit wrap
        idle();
        wr(12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
        tick(1);
        idle();
        rd(12'hB00);
        #1;
        chk("wrap_written", u_rd.data, 64'hFFFF_FFFF_FFFF_FFFF);
        tick(1);
        chk("wrap_zero", u_rd.data, 64'h0);

        // Asynchronous reset mid-count, checked before the next edge
        idle();
        retire = RW'(1);
        tick(3);
        rst_n = 1'b0;
        #1;
        chk("async_rst_mcycle",   mcycle,   64'h0);
        chk("async_rst_minstret", minstret, 64'h0);
        rst_n = 1'b1;
        idle();

        // Randomized traffic, checked by the per-cycle compare
        for (int n = 0; n < 1500; n++) begin
            tick(1);
            case ($urandom_range(0, 2))
                0:       priv = msrh_pkg::PRV_U;
                1:       priv = msrh_pkg::PRV_S;
                default: priv = msrh_pkg::PRV_M;
            endcase
            retire     = RW'($urandom_range(0, msrh_conf_pkg::DISP_SIZE));
            u_rd.valid = ($urandom_range(0, 9) < 7);
            u_rd.addr  = ($urandom_range(0, 4) == 0) ? 12'($urandom) : rd_pool[$urandom_range(0, 15)];
            u_wr.valid = ($urandom_range(0, 9) < 3);
            u_wr.addr  = wr_pool[$urandom_range(0, 11)];
            u_wr.data  = ($urandom_range(0, 1) == 0) ? 64'h0 : 64'($urandom_range(0, 7));
            if ($urandom_range(0, 49) == 0) begin
                u_wr.addr = ($urandom_range(0, 1) == 0) ? 12'hB00 : 12'hB02;
                u_wr.data = {$urandom, $urandom};
            end
        end
        tick(1);
        idle();
        tick(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
